// File: rtl/spi_slave_engine.sv
// ---------------------------------------------------------------------------
// spi_slave_engine
//
// SPI slave-side byte engine. The SCLK, SS_N and MOSI pins are oversampled
// on clk through SYNC_STAGES-deep synchronizers. SCLK edges are detected
// internally, and full-duplex words of DATA_W bits are shifted MSB-first in
// any of the four CPOL/CPHA modes. Parallel data is exchanged through a TX
// holding register and an RX data register.
//
// Optional feature macro: SPI_SLAVE_OVERRUN_EN
//   defined   : a word completing while o_rx_valid is set and unread is
//               dropped and raises the sticky o_overrun flag.
//   undefined : a new word always overwrites o_rx_data; o_overrun is 0.
//
// Parameters
//   DATA_W       bits per transfer (>=2)
//   SYNC_STAGES  synchronizer flops per SPI input pin (>=2)
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   i_cpol, i_cpha  SPI mode, latched when slave select is asserted
//   i_spi_sclk      SPI clock pin (asynchronous)
//   i_spi_ss_n      slave select pin, active low (asynchronous)
//   i_spi_mosi      master-out data pin (asynchronous)
//   o_spi_miso      slave-out data, MSB of the TX shift register
//   o_miso_oe       MISO output enable, high only while selected
//   i_tx_data       word to transmit
//   i_tx_valid      write strobe for i_tx_data
//   o_tx_ready      TX holding register empty
//   o_rx_data       last received word
//   o_rx_valid      o_rx_data not yet read
//   i_rx_read       one-cycle pulse that consumes o_rx_data
//   o_overrun       sticky overrun flag
//   i_overrun_clr   clears o_overrun
// ---------------------------------------------------------------------------
module spi_slave_engine #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_spi_sclk,
  input  logic              i_spi_ss_n,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_read,
  output logic              o_overrun,
  input  logic              i_overrun_clr
);

  localparam int CW = $clog2(DATA_W);
  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // -------------------------------------------------------------------------
  // Pin synchronizers and SCLK edge detection
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '1;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   i_spi_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;

  // -------------------------------------------------------------------------
  // Select arming. The synchronizer resets to "deselected", so a pin that is
  // held low through reset would otherwise look like a fresh falling edge
  // once the chain fills. Selection is only honoured after a genuine high
  // level has been seen on the pin since reset.
  // -------------------------------------------------------------------------
  logic [FW-1:0] fill_cnt;
  logic          fill_done;
  logic          armed;

  assign fill_done = (fill_cnt == FW'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      if (!fill_done)
        fill_cnt <= fill_cnt + FW'(1);
      if (fill_done && ss_s)
        armed <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Transfer state
  // -------------------------------------------------------------------------
  state_t            state;
  logic              cpol_q, cpha_q;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  logic              entry;
  logic              active_go;
  logic              sample_edge;
  logic              setup_edge;
  logic              cnt_zero;
  logic              last_bit;
  logic              byte_done;
  logic              take_hold;
  logic              write_acc;
  logic              store;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] rx_next;

  // In IDLE a low synchronized select means a 1->0 transition has occurred
  // since the last high level (armed, or the exit from ACTIVE).
  assign entry       = (state == IDLE) && armed && !ss_s;
  // Deselect has priority over any edge seen in the same cycle.
  assign active_go   = (state == ACTIVE) && !ss_s;

  // Modes 0 and 3 sample on rising SCLK, modes 1 and 2 on falling SCLK.
  assign sample_edge = active_go && ((cpol_q ^ cpha_q) ? sclk_fall : sclk_rise);
  assign setup_edge  = active_go && ((cpol_q ^ cpha_q) ? sclk_rise : sclk_fall);

  assign cnt_zero    = (bit_cnt == '0);
  assign last_bit    = (bit_cnt == CW'(DATA_W - 1));
  assign byte_done   = sample_edge && last_bit;

  // A load uses the holding register if it has data, else a dummy all-ones
  // word. The load reads the pre-write holding content, so a write landing
  // on the same cycle is kept for the following word.
  assign load_val    = hold_full ? hold : '1;
  assign take_hold   = hold_full &&
                       ((entry && !i_cpha) || (setup_edge && cnt_zero));
  assign write_acc   = i_tx_valid && !hold_full;

  assign rx_next     = {rx_shift[DATA_W-2:0], mosi_s};

`ifdef SPI_SLAVE_OVERRUN_EN
  // Keep the unread word; the new one is dropped.
  assign store = !(rx_valid && !i_rx_read);
`else
  assign store = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      bit_cnt   <= '0;
      tx_shift  <= '1;
      rx_shift  <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      // TX holding register
      if (write_acc) begin
        hold      <= i_tx_data;
        hold_full <= 1'b1;
      end else if (take_hold) begin
        hold_full <= 1'b0;
      end

      // A read clears valid; a completing word below overrides this.
      if (i_rx_read)
        rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (entry) begin
            state    <= ACTIVE;
            cpol_q   <= i_cpol;
            cpha_q   <= i_cpha;
            bit_cnt  <= '0;
            rx_shift <= '0;
            // With cpha=1 the first setup edge performs the load.
            tx_shift <= i_cpha ? '1 : load_val;
          end
        end

        ACTIVE: begin
          if (ss_s) begin
            // Mid-word deselect: drop the partial word.
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '1;
          end else begin
            if (sample_edge) begin
              rx_shift <= rx_next;
              if (last_bit) begin
                bit_cnt <= '0;
                if (store) begin
                  rx_data  <= rx_next;
                  rx_valid <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
            if (setup_edge) begin
              if (cnt_zero)
                tx_shift <= load_val;
              else
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Overrun flag
  // -------------------------------------------------------------------------
`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun;

  always_ff @(posedge clk) begin
    if (reset)
      overrun <= 1'b0;
    else if (byte_done && rx_valid && !i_rx_read)
      overrun <= 1'b1;
    else if (i_overrun_clr)
      overrun <= 1'b0;
  end

  assign o_overrun = overrun;
`else
  logic unused_ovr;
  assign unused_ovr = i_overrun_clr ^ byte_done;
  assign o_overrun  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_spi_miso = tx_shift[DATA_W-1];
  assign o_miso_oe  = (state == ACTIVE);
  assign o_tx_ready = !hold_full;
  assign o_rx_data  = rx_data;
  assign o_rx_valid = rx_valid;

endmodule

// File: tb/tb_spi_slave_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_engine
//
// Directed bench for spi_slave_engine: a behavioural SPI master drives the
// pins in all four modes while the register side is poked through tasks.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_spi_slave_engine;

  localparam int H = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       cpol, cpha;
  logic       sclk, ss_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read;
  logic       overrun;
  logic       overrun_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_slave_engine #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cpol        (cpol),
    .i_cpha        (cpha),
    .i_spi_sclk    (sclk),
    .i_spi_ss_n    (ss_n),
    .i_spi_mosi    (mosi),
    .o_spi_miso    (miso),
    .o_miso_oe     (miso_oe),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .i_rx_read     (rx_read),
    .o_overrun     (overrun),
    .i_overrun_clr (overrun_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_read();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic pulse_ovr_clr();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    @(negedge clk);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    wait_clk(10);
  endtask

  task automatic select();
    @(negedge clk);
    ss_n = 1'b0;
    wait_clk(10);
  endtask

  task automatic deselect();
    @(negedge clk);
    ss_n = 1'b1;
    wait_clk(10);
  endtask

  // Master side: shifts nbits of mo out MSB-first, captures MISO.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[7-i];
        wait_clk(H);
        mi   = {mi[6:0], miso};
        sclk = ~cpol;
        wait_clk(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[7-i];
        wait_clk(H);
        mi   = {mi[6:0], miso};
        sclk = cpol;
        wait_clk(H);
      end
    end
    wait_clk(H);
  endtask

  task automatic run_mode(input logic pol, input logic pha);
    logic [7:0] mi;
    set_mode(pol, pha);
    write_tx(8'hA5);
    check("mode_tx_ready_after_write", tx_ready, 1'b0);
    select();
    check("mode_oe_selected", miso_oe, 1'b1);
    // cpha=0 loads at select, cpha=1 waits for the first SCLK edge.
    check("mode_tx_ready_after_select", tx_ready, pha ? 1'b0 : 1'b1);
    xfer(8'h3C, 8, mi);
    check("mode_miso_byte", mi, 8'hA5);
    check("mode_rx_data", rx_data, 8'h3C);
    check("mode_rx_valid", rx_valid, 1'b1);
    check("mode_tx_ready_end", tx_ready, 1'b1);
    pulse_read();
    check("mode_rx_valid_cleared", rx_valid, 1'b0);
    deselect();
    check("mode_oe_deselected", miso_oe, 1'b0);
  endtask

  initial begin
    logic [7:0] mi;
    reset       = 1'b1;
    cpol        = 1'b0;
    cpha        = 1'b0;
    sclk        = 1'b0;
    ss_n        = 1'b1;
    mosi        = 1'b1;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    rx_read     = 1'b0;
    overrun_clr = 1'b0;
    wait_clk(3);

    // Reset state
    check("rst_miso", miso, 1'b1);
    check("rst_oe", miso_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    wait_clk(5);

    // All four modes, 0xA5 out / 0x3C in
    run_mode(1'b0, 1'b0);
    run_mode(1'b0, 1'b1);
    run_mode(1'b1, 1'b0);
    run_mode(1'b1, 1'b1);

    // Back-to-back words, holding empty for the second
    set_mode(1'b0, 1'b0);
    write_tx(8'hA5);
    select();
    xfer(8'h11, 8, mi);
    check("b2b_miso_1", mi, 8'hA5);
    check("b2b_rx_data_1", rx_data, 8'h11);
    check("b2b_rx_valid_1", rx_valid, 1'b1);
    pulse_read();
    check("b2b_rx_valid_read", rx_valid, 1'b0);
    xfer(8'h22, 8, mi);
    check("b2b_miso_2", mi, 8'hFF);
    check("b2b_rx_data_2", rx_data, 8'h22);
    check("b2b_rx_valid_2", rx_valid, 1'b1);
    pulse_read();
    deselect();

    // Second word completes without a read
    select();
    xfer(8'h55, 8, mi);
    check("ovr_rx_data_1", rx_data, 8'h55);
    xfer(8'h66, 8, mi);
    check("ovr_rx_valid", rx_valid, 1'b1);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("ovr_flag_set", overrun, 1'b1);
    check("ovr_rx_data_kept", rx_data, 8'h55);
`else
    check("ovr_flag_zero", overrun, 1'b0);
    check("ovr_rx_data_overwritten", rx_data, 8'h66);
`endif
    pulse_ovr_clr();
    check("ovr_flag_cleared", overrun, 1'b0);
    pulse_read();
    check("ovr_rx_valid_read", rx_valid, 1'b0);
    deselect();

    // Deselect after 5 bits, then a full 0x81
    select();
    xfer(8'hFF, 5, mi);
    deselect();
    check("partial_no_valid", rx_valid, 1'b0);
    select();
    xfer(8'h81, 8, mi);
    check("partial_next_rx_data", rx_data, 8'h81);
    check("partial_next_rx_valid", rx_valid, 1'b1);
    deselect();

    // Reset in the middle of a word, select still held low
    write_tx(8'h5A);
    select();
    xfer(8'hF0, 3, mi);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_miso", miso, 1'b1);
    check("mid_rst_oe", miso_oe, 1'b0);
    check("mid_rst_tx_ready", tx_ready, 1'b1);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    reset = 1'b0;
    wait_clk(20);
    check("mid_rst_no_reentry", miso_oe, 1'b0);
    deselect();
    select();
    check("mid_rst_reentry", miso_oe, 1'b1);
    xfer(8'h42, 8, mi);
    check("mid_rst_miso_dummy", mi, 8'hFF);
    check("mid_rst_rx_data_new", rx_data, 8'h42);
    check("mid_rst_rx_valid_new", rx_valid, 1'b1);
    deselect();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
